// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the two-master bus arbiter and the master control
// paths that talk to it.
//   state_t   : arbiter FSM state (IDLE / GNT1 / GNT2)
//   owner_t   : bus owner code as seen on the arbiter's owner output
//   state_to_owner() : maps a grant state onto its owner code
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t GNT1 = 2'b01;
  localparam state_t GNT2 = 2'b10;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE = 2'b00;
  localparam owner_t OWNER_M1   = 2'b01;
  localparam owner_t OWNER_M2   = 2'b10;

  // Grant states and owner codes share an encoding today, but the mapping is
  // kept explicit so either side can be re-encoded without surprises.
  function automatic owner_t state_to_owner(input state_t s);
    owner_t o;
    case (s)
      GNT1:    o = OWNER_M1;
      GNT2:    o = OWNER_M2;
      default: o = OWNER_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bus_arbiter_2m_tenure_counter.sv
// ---------------------------------------------------------------------------
// tenure_counter
// Counts granted cycles of the current bus owner, saturating one below the
// tenure limit so the arbiter can detect "tenure used up".
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : force the count to zero (takes priority over enable_i)
//   enable_i     : count this cycle
//   at_limit_o   : count has reached MAX_TENURE-1
// Parameters:
//   CNT_W        : counter width, must hold MAX_TENURE
//   MAX_TENURE   : tenure limit in cycles (2..255)
// ---------------------------------------------------------------------------
module tenure_counter #(
  parameter int CNT_W      = 8,
  parameter int MAX_TENURE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_TENURE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise step up until the limit and then hold,
  // so a lone master can keep the bus indefinitely without wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m
// Two-master shared-bus arbiter. At most one grant at a time, a one-cycle
// dead bus (IDLE) between owners, and a bounded tenure whenever the other
// master is waiting.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   busreq_1/busreq_2  : bus requests from master 1 / master 2
//   grant_1/grant_2    : registered grants
//   owner              : 00 none, 01 master 1, 10 master 2
//   bus_busy           : either grant active
//   timeout            : one-cycle pulse when a tenure is forcibly ended
// Parameters:
//   MAX_TENURE (2..255), CNT_W (tenure counter width)
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, ties alternate between masters;
//                        otherwise master 1 has fixed priority.
// ---------------------------------------------------------------------------
module bus_arbiter_2m
  import bus_arb_pkg::*;
#(
  parameter int MAX_TENURE = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busreq_1,
  input  logic       busreq_2,
  output logic       grant_1,
  output logic       grant_2,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       timeout
);

  state_t state_q, state_d;
  owner_t last_owner_q, last_owner_d;
  logic   preempt_q, preempt_d;
  logic   timeout_q, timeout_d;
  logic   grant_1_q, grant_2_q, bus_busy_q;
  owner_t owner_q;

  state_t tie_winner;
  logic   at_limit;

  // The counter sits at zero through every dead IDLE cycle, which is what
  // gives "cleared on entry to GNTx" since every grant starts from IDLE.
  tenure_counter #(
    .CNT_W      (CNT_W),
    .MAX_TENURE (MAX_TENURE)
  ) u_tenure (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == IDLE),
    .enable_i   (state_q != IDLE),
    .at_limit_o (at_limit)
  );

  // Tie-break. The preempted master is always last_owner (it was the one
  // holding the bus when its tenure was cut), so a pending preemption hands
  // the tie to the other master. Without preemption the build option picks
  // alternation or fixed master-1 priority.
  always_comb begin
    tie_winner = GNT1;
    if (preempt_q) begin
      tie_winner = (last_owner_q == OWNER_M1) ? GNT2 : GNT1;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      tie_winner = (last_owner_q == OWNER_M1) ? GNT2 : GNT1;
`else
      tie_winner = GNT1;
`endif
    end
  end

  // Arbitration FSM. A voluntary release takes precedence over a timeout in
  // the same cycle, so a master dropping its request on its last allowed
  // cycle is not flagged as preempted.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    preempt_d    = preempt_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (busreq_1 && busreq_2) begin
          state_d = tie_winner;
        end else if (busreq_1) begin
          state_d = GNT1;
        end else if (busreq_2) begin
          state_d = GNT2;
        end
        if (state_d != IDLE) begin
          preempt_d    = 1'b0;
          last_owner_d = state_to_owner(state_d);
        end
      end
      GNT1: begin
        if (!busreq_1) begin
          state_d = IDLE;
        end else if (at_limit && busreq_2) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          preempt_d = 1'b1;
        end
      end
      GNT2: begin
        if (!busreq_2) begin
          state_d = IDLE;
        end else if (at_limit && busreq_1) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          preempt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, history and output registers. Outputs are registered from the
  // next state so they change on the same edge as the state itself, and the
  // asynchronous reset pulls every grant low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_M2;
      preempt_q    <= 1'b0;
      timeout_q    <= 1'b0;
      grant_1_q    <= 1'b0;
      grant_2_q    <= 1'b0;
      bus_busy_q   <= 1'b0;
      owner_q      <= OWNER_NONE;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      preempt_q    <= preempt_d;
      timeout_q    <= timeout_d;
      grant_1_q    <= (state_d == GNT1);
      grant_2_q    <= (state_d == GNT2);
      bus_busy_q   <= (state_d != IDLE);
      owner_q      <= state_to_owner(state_d);
    end
  end

  assign grant_1  = grant_1_q;
  assign grant_2  = grant_2_q;
  assign owner    = owner_q;
  assign bus_busy = bus_busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Scoreboard bench for bus_arbiter_2m (MAX_TENURE = 4). Each stimulus cycle
// advances a behavioural model of the arbitration rules and queues the
// outputs it expects; a monitor on the falling edge pops and compares.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_2m;

  localparam int MAX_T = 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busreq_1 = 1'b0;
  logic       busreq_2 = 1'b0;
  logic       grant_1, grant_2, bus_busy, timeout;
  logic [1:0] owner;

  typedef struct {
    int         tag;
    logic       g1;
    logic       g2;
    logic [1:0] own;
    logic       busy;
    logic       tmo;
  } expect_t;

  expect_t sb[$];
  int errors = 0;
  int checks = 0;
  int cycleNum = 0;

  // Reference model: who holds the bus, for how many granted cycles, who held
  // it last, and which master (if any) was cut off and still owes a turn.
  int   mOwner;
  int   mHeld;
  int   mLast;
  int   mPreempted;
  logic mTimeout;

  bus_arbiter_2m #(
    .MAX_TENURE (MAX_T),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .busreq_1 (busreq_1),
    .busreq_2 (busreq_2),
    .grant_1  (grant_1),
    .grant_2  (grant_2),
    .owner    (owner),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mOwner     = 0;
    mHeld      = 0;
    mLast      = 2;
    mPreempted = 0;
    mTimeout   = 1'b0;
  endfunction

  // One rising edge of the arbitration rules, given the sampled requests.
  function automatic void modelStep(input logic r1, input logic r2);
    logic req [1:2];
    int   w;
    req[1]   = r1;
    req[2]   = r2;
    mTimeout = 1'b0;
    if (mOwner == 0) begin
      w = 0;
      if (r1 && r2) begin
        if (mPreempted != 0)  w = 3 - mPreempted;
        else if (ROUND_ROBIN) w = 3 - mLast;
        else                  w = 1;
      end else if (r1) begin
        w = 1;
      end else if (r2) begin
        w = 2;
      end
      if (w != 0) begin
        mOwner     = w;
        mLast      = w;
        mHeld      = 0;
        mPreempted = 0;
      end
    end else begin
      mHeld = mHeld + 1;
      if (!req[mOwner]) begin
        mOwner = 0;
      end else if (req[3 - mOwner] && mHeld >= MAX_T) begin
        mPreempted = mOwner;
        mOwner     = 0;
        mTimeout   = 1'b1;
      end
    end
  endfunction

  function automatic void pushExpected();
    expect_t e;
    e.tag  = cycleNum;
    e.g1   = (mOwner == 1);
    e.g2   = (mOwner == 2);
    e.own  = 2'(mOwner);
    e.busy = (mOwner != 0);
    e.tmo  = mTimeout;
    sb.push_back(e);
  endfunction

  // Drive one cycle: set inputs, let the DUT see an edge, advance the model
  // and queue the expectation for that cycle. midReset raises rst partway
  // through the cycle, after the edge, to exercise the asynchronous path.
  task automatic applyStimulus(input logic r1, input logic r2,
                               input logic rstLevel, input logic midReset);
    rst      = rstLevel;
    busreq_1 = r1;
    busreq_2 = r2;
    @(posedge clk);
    #1;
    cycleNum = cycleNum + 1;
    if (rst) modelReset();
    else     modelStep(busreq_1, busreq_2);
    if (midReset) begin
      rst = 1'b1;
      modelReset();
    end
    pushExpected();
  endtask

  task automatic checkOutput(input expect_t e);
    checks = checks + 1;
    if (grant_1 !== e.g1 || grant_2 !== e.g2 || owner !== e.own ||
        bus_busy !== e.busy || timeout !== e.tmo) begin
      errors = errors + 1;
      $display("[TB] FAIL cycle%0d: got g1=%0b g2=%0b owner=%b busy=%0b timeout=%0b, expected g1=%0b g2=%0b owner=%b busy=%0b timeout=%0b",
               e.tag, grant_1, grant_2, owner, bus_busy, timeout,
               e.g1, e.g2, e.own, e.busy, e.tmo);
    end
  endtask

  // Monitor: compares whatever the stimulus side has queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    logic r1, r2;
    modelReset();
    #1 rst = 1'b1;

    // Reset held with master 1 requesting: no grant may appear.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Single master request and release.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Tie from IDLE, master 1 leaves, master 2 follows; then a second tie.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Both held high: tenure limit, timeout pulse, handover.
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Lone master well past the tenure limit, then a late competitor.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-cycle while master 2 owns the bus; tie afterwards.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with sticky requests so long tenures and ties occur.
    r1 = 1'b0;
    r2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (r1) r1 = ($urandom_range(0, 7) != 0);
      else    r1 = ($urandom_range(0, 2) == 0);
      if (r2) r2 = ($urandom_range(0, 7) != 0);
      else    r2 = ($urandom_range(0, 2) == 0);
      applyStimulus(r1, r2, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
